// File: rtl/axi4_stream_fifo.sv
// First-word fall-through AXI4-Stream FIFO with TLAST, level and almost flags.
// Optional packet mode (hold output until a whole packet is stored): AXIS_FIFO_PACKET_MODE_EN.
module axi4_stream_fifo #(
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ALMOST_FULL  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [DATA_SIZE-1:0]         read_data,
  input  logic                         read_data_last,
  input  logic                         read_data_valid,
  output logic                         read_data_ready,
  output logic [DATA_SIZE-1:0]         write_data,
  output logic                         write_data_last,
  output logic                         write_data_valid,
  input  logic                         write_data_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full,
  output logic                         almost_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);
  localparam logic [LvlW-1:0] LvlAf   = LvlW'(ALMOST_FULL);
  localparam logic [LvlW-1:0] LvlAe   = LvlW'(ALMOST_EMPTY);

  logic [DATA_SIZE:0] r_mem [DEPTH];
  logic [PtrW-1:0]    r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
  logic [LvlW-1:0]    r_level, w_level_d;
  logic               w_push, w_pop;

  // No full pass-through: a pop in the same cycle does not open the input.
  assign read_data_ready = (r_level != LvlFull);
  assign w_push          = read_data_valid & read_data_ready;
  assign w_pop           = write_data_valid & write_data_ready;

  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_level_d  = r_level;
    if (w_push) w_wr_ptr_d = r_wr_ptr + 1'b1;
    if (w_pop)  w_rd_ptr_d = r_rd_ptr + 1'b1;
    case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + 1'b1;
      2'b01:   w_level_d = r_level - 1'b1;
      default: w_level_d = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_level  <= w_level_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (resetn && w_push) r_mem[r_wr_ptr] <= {read_data_last, read_data};
  end

  assign {write_data_last, write_data} = r_mem[r_rd_ptr];

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [LvlW-1:0] r_pkt_count, w_pkt_count_d;
  logic            w_pkt_in, w_pkt_out;

  assign w_pkt_in  = w_push & read_data_last;
  assign w_pkt_out = w_pop & write_data_last;

  always_comb begin
    w_pkt_count_d = r_pkt_count;
    case ({w_pkt_in, w_pkt_out})
      2'b10:   w_pkt_count_d = r_pkt_count + 1'b1;
      2'b01:   w_pkt_count_d = r_pkt_count - 1'b1;
      default: w_pkt_count_d = r_pkt_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_pkt_count <= '0;
    else         r_pkt_count <= w_pkt_count_d;
  end

  // Full override releases packets longer than DEPTH; pkt_count only drops on a pop,
  // so valid cannot fall before its handshake.
  assign write_data_valid = (r_level != '0) & ((r_pkt_count != '0) | (r_level == LvlFull));
`else
  assign write_data_valid = (r_level != '0);
`endif

  assign level        = r_level;
  assign almost_full  = (r_level >= LvlAf);
  assign almost_empty = (r_level <= LvlAe);

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Randomised self-checking bench for axi4_stream_fifo against a queue-based reference model.
module tb_axi4_stream_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] in_data;
  logic          in_last, in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic          out_last, out_valid, out_ready;
  logic [4:0]    level;
  logic          af, ae;

  int checks   = 0;
  int failures = 0;

  // Reference contents: {last, data}, head at index 0.
  logic [DW:0] mq[$];

  axi4_stream_fifo #(
    .DATA_SIZE   (DW),
    .DEPTH       (DEPTH),
    .ALMOST_FULL (DEPTH - 2),
    .ALMOST_EMPTY(1)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .read_data       (in_data),
    .read_data_last  (in_last),
    .read_data_valid (in_valid),
    .read_data_ready (in_ready),
    .write_data      (out_data),
    .write_data_last (out_last),
    .write_data_valid(out_valid),
    .write_data_ready(out_ready),
    .level           (level),
    .almost_full     (af),
    .almost_empty    (ae)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit model_valid();
    if (mq.size() == 0) return 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    if (mq.size() == DEPTH) return 1'b1;
    foreach (mq[i]) if (mq[i][DW]) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // One clock edge; the model applies the handshakes implied by the current inputs.
  task automatic tick();
    bit push, pop;
    push = in_valid && (mq.size() != DEPTH);
    pop  = out_ready && model_valid();
    if (!resetn) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({in_last, in_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    tick(); tick();
    resetn = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (ae !== 1'b1) begin failures++; $display("FAIL reset_ae got %b want 1", ae); end
    checks++; if (af !== 1'b0) begin failures++; $display("FAIL reset_af got %b want 0", af); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp [3];
    exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
    idle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = exp[i]; in_last = (i == 2);
      tick();
    end
    idle();
    checks++; if (level !== 5'd3) begin failures++; $display("FAIL basic_level got %0d want 3", level); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 2)) begin
        failures++;
        $display("FAIL basic_out%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, out_valid, out_data, out_last, exp[i], (i == 2));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL basic_drain_level got %0d want 0", level); end
    checks++; if (ae !== 1'b1) begin failures++; $display("FAIL basic_drain_ae got %b want 1", ae); end
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (level !== 5'(i) || af !== (i >= 14) || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL full_fill%0d got lvl=%0d af=%b rdy=%b want lvl=%0d af=%b rdy=1",
                 i, level, af, in_ready, i, (i >= 14));
      end
      in_valid = 1'b1; in_data = 32'(i); in_last = 1'b0;
      tick();
    end
    checks++;
    if (level !== 5'd16 || in_ready !== 1'b0 || af !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_state got lvl=%0d rdy=%b af=%b v=%b want 16 0 1 1", level, in_ready, af, out_valid);
    end
    in_data = 32'hBAD;
    tick();
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL full_overflow got %0d want 16", level); end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL full_head got %h want 0", out_data); end
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || level !== 5'd15) begin
      failures++;
      $display("FAIL full_after_pop got rdy=%b lvl=%0d want 1 15", in_ready, level);
    end
    in_valid = 1'b1; in_data = 32'h77; in_last = 1'b1;
    tick();
    idle();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== ((k < 15) ? 32'(k + 1) : 32'h77)) begin
        failures++;
        $display("FAIL full_drain%0d got v=%b d=%h want v=1 d=%h", k, out_valid, out_data,
                 ((k < 15) ? 32'(k + 1) : 32'h77));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (level !== 5'd0 || ae !== 1'b1) begin failures++; $display("FAIL full_empty got lvl=%0d ae=%b want 0 1", level, ae); end
  endtask

  task automatic test_stream();
    idle();
    in_valid = 1'b1; out_ready = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = 32'h1000 + 32'(i);
      if (i > 0) begin
        checks++;
        if (level !== 5'd1 || out_valid !== 1'b1 || out_data !== 32'h1000 + 32'(i - 1)) begin
          failures++;
          $display("FAIL stream%0d got lvl=%0d v=%b d=%h want 1 1 %h", i, level, out_valid, out_data,
                   32'h1000 + 32'(i - 1));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_data !== 32'h103F) begin failures++; $display("FAIL stream_tail got %h want 103f", out_data); end
    tick();
    idle();
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL stream_end_level got %0d want 0", level); end
  endtask

  task automatic test_random();
    int idx = 0, popped = 0, cyc = 0;
    bit pushed, popd;
    idle();
    in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
    while (popped < 1000 && cyc < 20000) begin
      checks++;
      if (level !== 5'(mq.size()) || in_ready !== (mq.size() != DEPTH) || out_valid !== model_valid()
          || af !== (mq.size() >= DEPTH - 2) || ae !== (mq.size() <= 1)) begin
        failures++;
        $display("FAIL random_state c%0d got lvl=%0d rdy=%b v=%b af=%b ae=%b want lvl=%0d v=%b",
                 cyc, level, in_ready, out_valid, af, ae, mq.size(), model_valid());
      end
      if (model_valid()) begin
        checks++;
        if ({out_last, out_data} !== mq[0]) begin
          failures++;
          $display("FAIL random_data c%0d got %h want %h", cyc, {out_last, out_data}, mq[0]);
        end
      end
      pushed = in_valid && (mq.size() != DEPTH);
      popd   = out_ready && model_valid();
      tick();
      cyc++;
      if (pushed) idx++;
      if (popd)   popped++;
      if (pushed || !in_valid) begin
        in_valid = (idx < 1000) && ($urandom_range(0, 1) == 1);
        in_data  = $urandom;
        in_last  = ((idx % 7) == 6) || (idx == 999);
      end
      out_ready = ($urandom_range(0, 1) == 1);
    end
    idle();
    checks++; if (popped != 1000) begin failures++; $display("FAIL random_count got %0d want 1000", popped); end
  endtask

  task automatic test_mid_reset();
    idle();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h50 + 32'(i); in_last = 1'b1;
      tick();
    end
    idle();
    checks++; if (level !== 5'd5 || ae !== 1'b0) begin failures++; $display("FAIL mreset_pre got lvl=%0d ae=%b want 5 0", level, ae); end
    resetn = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; in_last = 1'b1; out_ready = 1'b1;
    tick();
    resetn = 1'b1;
    idle();
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mreset_post got lvl=%0d v=%b rdy=%b want 0 0 1", level, out_valid, in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'hA0 + 32'(i); in_last = 1'b1;
      tick();
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA0 + 32'(i)) begin
        failures++;
        $display("FAIL mreset_out%0d got v=%b d=%h want 1 %h", i, out_valid, out_data, 32'hA0 + 32'(i));
      end
      tick();
    end
    idle();
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL mreset_end got %0d want 0", level); end
  endtask

`ifdef AXIS_FIFO_PACKET_MODE_EN
  task automatic test_packet();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pkt_hold%0d got %b want 0", i, out_valid); end
      in_valid = 1'b1; in_data = 32'hC0 + 32'(i); in_last = (i == 2);
      tick();
      in_valid = 1'b0;
      if (i < 2) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pkt_early%0d got %b want 0", i, out_valid); end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hC0) begin
      failures++;
      $display("FAIL pkt_release got v=%b d=%h want 1 c0", out_valid, out_data);
    end
    for (int i = 0; i < 3; i++) tick();
    idle();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL pkt_long_hold%0d got %b want 0", i, out_valid); end
      in_valid = 1'b1; in_data = 32'(i); in_last = 1'b0;
      tick();
    end
    idle();
    checks++; if (out_valid !== 1'b1 || level !== 5'd16) begin failures++; $display("FAIL pkt_full_release got v=%b lvl=%0d want 1 16", out_valid, level); end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stream();
    test_random();
    test_mid_reset();
`ifdef AXIS_FIFO_PACKET_MODE_EN
    test_packet();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
